// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one partial product per clock, WIDTH iterations per operation.
// The product register holds its value until the next completed operation overwrites it.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic [PW-1:0]     acc_sum;

  // Operands are zero-extended, so the 2*WIDTH-bit sum can never overflow.
  assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, a};
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          p_d     = acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign p    = p_q;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, giving the unsigned operand width; legal range 2..16.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be input, 1 bit: synchronous, active-high reset.
REQ-004 Port start SHALL be input, 1 bit: request to begin a multiply, sampled on the rising edge.
REQ-005 Port a SHALL be input, WIDTH bits: unsigned multiplicand, sampled with start.
REQ-006 Port b SHALL be input, WIDTH bits: unsigned multiplier, sampled with start.
REQ-007 Port busy SHALL be output, 1 bit: high while an operation is in progress (state RUN or DONE).
REQ-008 Port done SHALL be output, 1 bit: single-cycle pulse marking a valid new product.
REQ-009 Port p SHALL be output, 2*WIDTH bits: registered product a*b.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 In IDLE, start=1 at an edge SHALL latch a into multiplicand register mcand (2*WIDTH bits, zero-extended), latch b into multiplier register mplr (WIDTH bits), clear accumulator acc (2*WIDTH bits), clear iteration counter cnt, and enter RUN.
REQ-012 In IDLE, start=0 SHALL leave all registers unchanged.
REQ-013 In RUN, each edge SHALL: add mcand to acc if mplr[0]=1; shift mcand left 1 (zero fill); shift mplr right 1 (zero fill); increment cnt.
REQ-014 Addition in acc SHALL be 2*WIDTH bits wide with no overflow possible (max (2^WIDTH-1)^2 fits).
REQ-015 On the RUN edge where cnt reaches WIDTH-1 (the WIDTH-th iteration), the FSM SHALL load p with the final accumulated value and enter DONE.
REQ-016 In DONE, done SHALL be 1 for exactly that one cycle; the next edge SHALL return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the edge that sampled start; throughput one result per WIDTH+2 cycles.
REQ-018 start SHALL be ignored while busy=1 (RUN or DONE); a, b changes during RUN SHALL not affect the result.
REQ-019 p SHALL hold its last value through IDLE and RUN until the next DONE overwrites it.
REQ-020 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operation).
REQ-021 busy SHALL be 1 in RUN and DONE, 0 in IDLE; done SHALL be 0 outside DONE.
REQ-022 Operand value 0 (either input) SHALL still take the full WIDTH iterations and produce p=0.

Reset
REQ-023 reset=1 at an edge SHALL force state IDLE, p=0, acc=0, mcand=0, mplr=0, cnt=0, busy=0, done=0, regardless of state.
REQ-024 reset SHALL have priority over start on the same edge; the start is discarded.
REQ-025 reset asserted mid-RUN or during DONE SHALL abort the operation with no done pulse and p=0.

Verification
REQ-026 WIDTH=4, a=3, b=3, pulse start -> busy high, done pulse 4 edges later, p=9; repeat b=0..3 with a=3 -> p=0,3,6,9.
REQ-027 WIDTH=4, a=15, b=15 -> p=225 (8'hE1); a=0, b=13 -> p=0 after full latency.
REQ-028 WIDTH=4, start a=5, b=6; during RUN drive start=1, a=9, b=9 -> single done, p=30, second start ignored.
REQ-029 WIDTH=4, a=7, b=9, assert reset 2 cycles into RUN -> busy=0, done never pulses, p=0; next start a=2, b=3 -> p=6.
REQ-030 Back-to-back: start a=4, b=4, then start in first IDLE cycle with a=12, b=11 -> p=16 then p=132, two done pulses 6 cycles apart.
REQ-031 WIDTH=8 instance, a=255, b=255 -> p=65025 after 8-cycle latency; random a, b (200 vectors) match a*b.
